// File: rtl/counter_pkg.sv
// Shared types for the modulo-N counter block.
package counter_pkg;

    // Two-state control FSM: counting normally, or parked after a one-shot terminal step.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/modn_counter_if.sv
// Control/status bundle for modn_counter. The master drives the controls; the counter is the slave.
interface modn_counter_if #(
    parameter int WIDTH = 10
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic             oneshot;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             done;

    modport master (
        output en, up, clr, load, load_val, limit, oneshot,
        input  q, tc, wrap, done
    );

    modport slave (
        input  en, up, clr, load, load_val, limit, oneshot,
        output q, tc, wrap, done
    );
endinterface

// File: rtl/modn_next.sv
// Combinational next-value logic: one enabled step (with wrap/halt decisions) and the load clamp.
module modn_next
    import counter_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             oneshot,
    output logic [WIDTH-1:0] nxt_q,
    output logic [WIDTH-1:0] load_q,
    output logic             roll,
    output logic             halt
);

    // Step result for an enabled cycle; roll marks a wrap-mode rollover, halt a one-shot stop.
    always_comb begin
        nxt_q = q;
        roll  = 1'b0;
        halt  = 1'b0;
        if (up) begin
            // q above limit (limit lowered mid-count) is treated like the terminal value.
            if (q < limit) begin
                nxt_q = q + 1'b1;
            end else if (oneshot) begin
                nxt_q = limit;
                halt  = 1'b1;
            end else begin
                nxt_q = '0;
                roll  = 1'b1;
            end
        end else begin
            // Out-of-range q snaps back to limit without counting as a rollover.
            if (q > limit) begin
                nxt_q = limit;
            end else if (q == '0) begin
                if (oneshot) begin
                    halt = 1'b1;
                end else begin
                    nxt_q = limit;
                    roll  = 1'b1;
                end
            end else begin
                nxt_q = q - 1'b1;
            end
        end
    end

    // Parallel loads never place q outside 0..limit.
    always_comb begin
        load_q = (load_val > limit) ? limit : load_val;
    end

endmodule

// File: rtl/modn_counter.sv
// Runtime-modulus up/down counter with wrap or one-shot mode; holds the registers and FSM.
module modn_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           reset,
    modn_counter_if.slave  bus
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nxt_q;
    logic [WIDTH-1:0] load_q;
    logic             roll;
    logic             halt_req;
    logic             wrap_r;
    state_t           state;

    modn_next #(.WIDTH(WIDTH)) u_next (
        .q        (q),
        .limit    (bus.limit),
        .load_val (bus.load_val),
        .up       (bus.up),
        .oneshot  (bus.oneshot),
        .nxt_q    (nxt_q),
        .load_q   (load_q),
        .roll     (roll),
        .halt     (halt_req)
    );

    // Count register, FSM and wrap pulse: clr > load > enabled step (RUN only) > hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q      <= RESET_VAL;
            state  <= ST_RUN;
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            if (bus.clr) begin
                q     <= '0;
                state <= ST_RUN;
            end else if (bus.load) begin
                q     <= load_q;
                state <= ST_RUN;
            end else if (bus.en && state == ST_RUN) begin
                q      <= nxt_q;
                wrap_r <= roll;
                if (halt_req) state <= ST_HALT;
            end
        end
    end

    assign bus.q    = q;
    assign bus.wrap = wrap_r;
    assign bus.done = (state == ST_HALT);
    // Terminal count is forced low while reset is held so it never glitches during reset.
    assign bus.tc   = ~reset & bus.en & (state == ST_RUN) &
                      ((bus.up & (q >= bus.limit)) | (~bus.up & (q == '0)));

endmodule

// File: tb/tb_modn_counter.sv
// Self-checking bench for modn_counter: directed scenarios plus random traffic against a reference model.
module tb_modn_counter;
    localparam int W = 10;

    logic clk = 1'b0;
    logic reset;
    modn_counter_if #(.WIDTH(W)) bus();

    modn_counter #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: count value, halted flag, wrap pulse for the cycle after an edge.
    int mq;
    bit mhalt;
    bit mwrap;

    function automatic bit m_tc();
        int lim;
        lim = int'(bus.limit);
        return !reset && bus.en && !mhalt && ((bus.up && mq >= lim) || (!bus.up && mq == 0));
    endfunction

    function automatic void m_reset();
        mq = 0; mhalt = 0; mwrap = 0;
    endfunction

    // Range is 0..lim, i.e. modulus lim+1; the step is plain modular arithmetic on that range.
    function automatic void m_step();
        int lim;
        int m;
        lim   = int'(bus.limit);
        m     = lim + 1;
        mwrap = 0;
        if (bus.clr) begin
            mq = 0; mhalt = 0;
        end else if (bus.load) begin
            mq = (int'(bus.load_val) > lim) ? lim : int'(bus.load_val);
            mhalt = 0;
        end else if (bus.en && !mhalt) begin
            if (bus.up) begin
                if (mq >= lim && bus.oneshot) begin
                    mq = lim; mhalt = 1;
                end else begin
                    mwrap = (mq >= lim);
                    mq = (((mq < lim) ? mq : lim) + 1) % m;
                end
            end else if (mq > lim) begin
                mq = lim;
            end else if (mq == 0 && bus.oneshot) begin
                mhalt = 1;
            end else begin
                mwrap = (mq == 0);
                mq = (mq + m - 1) % m;
            end
        end
    endfunction

    task automatic set_in(input bit en, input bit up, input bit clr, input bit load,
                          input bit os, input int lv, input int lim);
        bus.en = en; bus.up = up; bus.clr = clr; bus.load = load; bus.oneshot = os;
        bus.load_val = W'(lv);
        bus.limit = W'(lim);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 5);
        m_reset();
        n_tests++; if (bus.q !== W'(0)) begin n_fail++; $display("FAIL reset_q got=%0d exp=0", bus.q); end
        n_tests++; if ({bus.wrap, bus.done} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {bus.wrap, bus.done}); end
        n_tests++; if (bus.tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc got=%b exp=0", bus.tc); end
        @(posedge clk); #1;
        n_tests++; if (bus.q !== W'(0)) begin n_fail++; $display("FAIL reset_hold_q got=%0d exp=0", bus.q); end
        reset = 1'b0;
    endtask

    task automatic test_async_reset();
        set_in(0, 1, 0, 1, 0, 500, 999); tick();
        n_tests++; if (bus.q !== W'(500)) begin n_fail++; $display("FAIL arst_load got=%0d exp=500", bus.q); end
        set_in(1, 1, 0, 0, 0, 0, 999);
        #1 reset = 1'b1;
        #1;
        n_tests++; if ({bus.q, bus.wrap, bus.done} !== {W'(0), 2'b00}) begin
            n_fail++; $display("FAIL arst_mid got q=%0d w=%b d=%b exp q=0 w=0 d=0", bus.q, bus.wrap, bus.done); end
        reset = 1'b0; m_reset();
        tick();
        n_tests++; if (bus.q !== W'(1)) begin n_fail++; $display("FAIL arst_first_step got=%0d exp=1", bus.q); end
        // Reset while halted.
        set_in(0, 1, 0, 1, 1, 2, 2); tick();
        set_in(1, 1, 0, 0, 1, 0, 2); tick();
        n_tests++; if ({bus.q, bus.done} !== {W'(2), 1'b1}) begin
            n_fail++; $display("FAIL arst_halt_setup got q=%0d d=%b exp q=2 d=1", bus.q, bus.done); end
        #1 reset = 1'b1;
        #1;
        n_tests++; if ({bus.q, bus.done} !== {W'(0), 1'b0}) begin
            n_fail++; $display("FAIL arst_halt got q=%0d d=%b exp q=0 d=0", bus.q, bus.done); end
        reset = 1'b0; m_reset();
        tick();
        n_tests++; if (bus.q !== W'(1)) begin n_fail++; $display("FAIL arst_halt_resume got=%0d exp=1", bus.q); end
    endtask

    task automatic test_sweep();
        set_in(0, 1, 1, 0, 0, 0, 999); tick();
        set_in(1, 1, 0, 0, 0, 0, 999);
        for (int i = 0; i < 1000; i++) begin
            n_tests++; if (bus.tc !== m_tc()) begin n_fail++; $display("FAIL sweep_tc i=%0d got=%b exp=%b", i, bus.tc, m_tc()); end
            if (i == 999) begin
                n_tests++; if (bus.tc !== 1'b1) begin n_fail++; $display("FAIL sweep_tc999 got=%b exp=1", bus.tc); end
            end
            tick();
            n_tests++; if ({bus.q, bus.wrap, bus.done} !== {W'(mq), mwrap, mhalt}) begin
                n_fail++; $display("FAIL sweep i=%0d got q=%0d w=%b d=%b exp q=%0d w=%b d=%b", i, bus.q, bus.wrap, bus.done, mq, mwrap, mhalt); end
        end
        n_tests++; if ({bus.q, bus.wrap} !== {W'(0), 1'b1}) begin
            n_fail++; $display("FAIL sweep_rollover got q=%0d w=%b exp q=0 w=1", bus.q, bus.wrap); end
    endtask

    task automatic test_oneshot_down();
        int       exp_q [6] = '{2, 1, 0, 0, 0, 0};
        bit [5:0] exp_d     = 6'b111000;
        set_in(0, 0, 0, 1, 1, 3, 9); tick();
        n_tests++; if (bus.q !== W'(3)) begin n_fail++; $display("FAIL os_load got=%0d exp=3", bus.q); end
        for (int i = 0; i < 6; i++) begin
            set_in(1, (i >= 4), 0, 0, (i != 5), 0, 9);
            tick();
            n_tests++; if ({bus.q, bus.done} !== {W'(exp_q[i]), exp_d[i]}) begin
                n_fail++; $display("FAIL os_down i=%0d got q=%0d d=%b exp q=%0d d=%b", i, bus.q, bus.done, exp_q[i], exp_d[i]); end
        end
        set_in(1, 1, 1, 0, 1, 0, 9); tick();
        n_tests++; if ({bus.q, bus.done} !== {W'(0), 1'b0}) begin
            n_fail++; $display("FAIL os_clr got q=%0d d=%b exp q=0 d=0", bus.q, bus.done); end
    endtask

    task automatic test_clr_load();
        set_in(1, 1, 1, 1, 0, 7, 15); tick();
        n_tests++; if (bus.q !== W'(0)) begin n_fail++; $display("FAIL clr_over_load got=%0d exp=0", bus.q); end
        set_in(0, 1, 0, 1, 0, 20, 15); tick();
        n_tests++; if (bus.q !== W'(15)) begin n_fail++; $display("FAIL load_clamp got=%0d exp=15", bus.q); end
    endtask

    task automatic test_limit_lower();
        set_in(0, 1, 0, 1, 0, 800, 999); tick();
        set_in(0, 1, 0, 0, 0, 0, 99); tick();
        n_tests++; if (bus.q !== W'(800)) begin n_fail++; $display("FAIL lower_hold got=%0d exp=800", bus.q); end
        set_in(1, 1, 0, 0, 0, 0, 99); tick();
        n_tests++; if ({bus.q, bus.wrap} !== {W'(0), 1'b1}) begin
            n_fail++; $display("FAIL lower_up got q=%0d w=%b exp q=0 w=1", bus.q, bus.wrap); end
        set_in(0, 1, 0, 1, 0, 800, 999); tick();
        set_in(1, 0, 0, 0, 0, 0, 99); tick();
        n_tests++; if ({bus.q, bus.wrap} !== {W'(99), 1'b0}) begin
            n_fail++; $display("FAIL lower_down got q=%0d w=%b exp q=99 w=0", bus.q, bus.wrap); end
    endtask

    task automatic test_limit_zero();
        set_in(0, 1, 1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 8; i++) begin
            set_in(1, i[0], 0, 0, 0, 0, 0);
            n_tests++; if (bus.tc !== 1'b1) begin n_fail++; $display("FAIL lim0_tc i=%0d got=%b exp=1", i, bus.tc); end
            tick();
            n_tests++; if ({bus.q, bus.wrap} !== {W'(0), 1'b1}) begin
                n_fail++; $display("FAIL lim0 i=%0d got q=%0d w=%b exp q=0 w=1", i, bus.q, bus.wrap); end
        end
    endtask

    task automatic test_random();
        int lim = 12;
        bit os  = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                lim = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1023));
            if ($urandom_range(0, 63) == 0) os = ~os;
            set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                   ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                   os, int'($urandom_range(0, 1023)), lim);
            n_tests++; if (bus.tc !== m_tc()) begin n_fail++; $display("FAIL rand_tc i=%0d got=%b exp=%b", i, bus.tc, m_tc()); end
            tick();
            n_tests++; if ({bus.q, bus.wrap, bus.done} !== {W'(mq), mwrap, mhalt}) begin
                n_fail++; $display("FAIL rand i=%0d got q=%0d w=%b d=%b exp q=%0d w=%b d=%b", i, bus.q, bus.wrap, bus.done, mq, mwrap, mhalt); end
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_sweep();
        test_oneshot_down();
        test_clr_load();
        test_limit_lower();
        test_limit_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/modn_counter.md
MODN_COUNTER -- requirements
Module: modn_counter

Interface
REQ-001 Parameter WIDTH, default 10, counter register width in bits.
REQ-002 Parameter RESET_VAL, default 0, value loaded into q on reset; must be less than 2**WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable; one step per enabled cycle.
REQ-006 up  input  1  direction: 1 counts up, 0 counts down.
REQ-007 clr  input  1  synchronous clear to 0.
REQ-008 load  input  1  synchronous parallel load from load_val.
REQ-009 load_val  input  WIDTH  parallel load value.
REQ-010 limit  input  WIDTH  runtime modulus minus one; count range is 0..limit inclusive; sampled every cycle.
REQ-011 oneshot  input  1  0 = free-running wrap mode, 1 = stop at terminal value.
REQ-012 q  output  WIDTH  registered count value.
REQ-013 tc  output  1  combinational terminal-count flag.
REQ-014 wrap  output  1  registered one-cycle pulse.
REQ-015 done  output  1  registered; high while halted in one-shot mode.

Function
REQ-016 Per-edge priority SHALL be clr > load > count step > hold.
REQ-017 clr SHALL set q=0, leave HALT for RUN, and keep wrap low.
REQ-018 load SHALL set q=min(load_val, limit), enter RUN, and keep wrap low.
REQ-019 The FSM SHALL have two states: RUN and HALT. done=1 exactly in HALT.
REQ-020 In RUN with en=1 and up=1: if q<limit, q<=q+1; if q>=limit, q<=0 in wrap mode, or q<=limit and enter HALT in one-shot mode.
REQ-021 In RUN with en=1 and up=0: if q>0 and q<=limit, q<=q-1; if q==0, q<=limit in wrap mode, or q holds 0 and HALT is entered in one-shot mode.
REQ-022 If q>limit, for example after limit is lowered mid-count, an enabled down step SHALL load q<=limit; an enabled up step SHALL follow REQ-020 (wrap to 0 or halt at limit).
REQ-023 In HALT, q SHALL hold regardless of en, up and changes to oneshot; only clr, load or reset leave HALT.
REQ-024 tc SHALL equal en & RUN & ((up & q>=limit) | (~up & q==0)).
REQ-025 wrap SHALL pulse high for the single cycle after a wrap-mode rollover: limit-to-0 when counting up, 0-to-limit when counting down.
REQ-026 Arithmetic SHALL be unsigned modulo 2**WIDTH with no carry out beyond WIDTH.
REQ-027 limit=0 SHALL keep q at 0; in wrap mode, wrap pulses after every enabled step.
REQ-028 With en=0, q and the FSM state SHALL hold; limit changes alone SHALL not alter q.

Reset
REQ-029 reset SHALL asynchronously force q=RESET_VAL, state=RUN, wrap=0 and done=0, independent of clk.
REQ-030 Reset asserted mid-count or in HALT SHALL take effect immediately; the first step after deassertion SHALL be evaluated from RESET_VAL.
REQ-031 tc SHALL read 0 while reset is high.

Structure
REQ-032 The FSM state enum (ST_RUN, ST_HALT) SHALL live in shared package counter_pkg.
REQ-033 Next-value arithmetic (step, wrap, clamp) SHALL be a combinational sub-module named modn_next; modn_counter holds the registers and the FSM.

Verification (WIDTH=10, RESET_VAL=0)
REQ-034 reset pulsed asynchronously mid-cycle at q=500 -> q=0 before the next edge; done=0 and wrap=0.
REQ-035 limit=999, up=1, oneshot=0, en=1 for 1000 cycles -> q steps 0..999 then 0; tc high on the q=999 cycle; wrap high the cycle after.
REQ-036 limit=9, up=0, oneshot=1, load with load_val=3 -> q=3,2,1,0 then holds 0; done=1; further en has no effect until clr.
REQ-037 Same-edge clr=1 and load=1 with load_val=7 -> q=0; load alone with load_val=20, limit=15 -> q=15.
REQ-038 At q=800 with limit lowered to 99 and up=1, en=1 -> next q=0 with wrap pulse; with up=0 instead -> next q=99.
REQ-039 limit=0, oneshot=0, en=1 -> q stays 0; wrap pulses after every enabled step; tc=1 on every enabled cycle.
